// File: rtl/rx_fifo_engine.sv
// rx_fifo_engine: UART receive engine that queues each received byte and its error flags in a 2^AW-entry FIFO.
// Define RX_BREAK_DETECT_EN to compile in break detection (brk flag and the BRK_WAIT state).
module rx_fifo_engine #(
    parameter int AW          = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        bit8,
    input  logic        pen,
    input  logic        ohel,
    input  logic [19:0] br,
    input  logic        read,
    output logic        rxrdy,
    output logic [7:0]  rx_out,
    output logic        perr,
    output logic        ferr,
    output logic        brk,
    output logic        ovf,
    output logic [AW:0] rx_level
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = LVL_ONE << AW;

`ifdef RX_BREAK_DETECT_EN
    localparam int EW = 11;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;
`else
    localparam int EW = 10;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   rx_hi_q, rx_hi_d;
    logic [19:0]            cnt_q, cnt_d;
    logic [19:0]            br_q, br_d;
    logic                   bit8_q, bit8_d;
    logic                   pen_q, pen_d;
    logic                   ohel_q, ohel_d;
    logic [7:0]             data_q, data_d;
    logic [2:0]             bidx_q, bidx_d;
    logic                   par_q, par_d;
    logic                   pbit_q, pbit_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [EW-1:0]          mem_q [DEPTH];

    logic                   rx_s;
    logic                   line_vld;
    logic                   sample;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   frame_perr;
    logic [19:0]            br_eff;
    logic [EW-1:0]          entry;
    logic [EW-1:0]          head;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    // The synchroniser resets to 1, so its output is not trusted until the pin has propagated through every stage.
    assign line_vld   = fill_q[SYNC_STAGES-1];
    assign sample     = (cnt_q == '0);
    assign br_eff     = (br < 20'd4) ? 20'd4 : br;
    assign frame_perr = pen_q & (pbit_q ^ par_q ^ ohel_q);

`ifdef RX_BREAK_DETECT_EN
    logic brk_frame;
    assign brk_frame = (data_q == 8'h00) && !(pen_q && pbit_q) && !rx_s;
    assign entry     = {brk_frame, ~rx_s, frame_perr, data_q};
`else
    assign entry     = {~rx_s, frame_perr, data_q};
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q before the case, so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        rx_hi_d = line_vld & rx_s;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bit8_d  = bit8_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        data_d  = data_q;
        bidx_d  = bidx_q;
        par_d   = par_q;
        pbit_d  = pbit_q;
        push    = 1'b0;

        if (state_q != S_IDLE && !sample) begin
            cnt_d = cnt_q - 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_hi_q && !rx_s) begin
                    br_d    = br_eff;
                    bit8_d  = bit8;
                    pen_d   = pen;
                    ohel_d  = ohel;
                    cnt_d   = {1'b0, br_eff[19:1]} - 20'd1;
                    data_d  = 8'h00;
                    bidx_d  = 3'd0;
                    par_d   = 1'b0;
                    pbit_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    cnt_d   = br_q - 20'd1;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    data_d[bidx_q] = rx_s;
                    par_d          = par_q ^ rx_s;
                    cnt_d          = br_q - 20'd1;
                    if (bidx_q == (bit8_q ? 3'd7 : 3'd6)) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    pbit_d  = rx_s;
                    cnt_d   = br_q - 20'd1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    push    = 1'b1;
                    // Re-arm as if the line had been high, so a low line right after the stop sample starts a new frame.
                    rx_hi_d = 1'b1;
                    state_d = S_IDLE;
`ifdef RX_BREAK_DETECT_EN
                    if (brk_frame) begin
                        state_d = S_BRK_WAIT;
                    end
`endif
                end
            end
`ifdef RX_BREAK_DETECT_EN
            S_BRK_WAIT: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = read && (count_q != '0);
        full     = (count_q == LVL_FULL);
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LVL_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - LVL_ONE;
        end
        ovf_d = ovf_q;
        if (pop) begin
            ovf_d = 1'b0;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values whatever the evaluation order.
        if (reset) begin
            state_q  <= S_IDLE;
            sync_q   <= '1;
            fill_q   <= '0;
            rx_hi_q  <= 1'b0;
            cnt_q    <= '0;
            br_q     <= '0;
            bit8_q   <= 1'b0;
            pen_q    <= 1'b0;
            ohel_q   <= 1'b0;
            data_q   <= '0;
            bidx_q   <= '0;
            par_q    <= 1'b0;
            pbit_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            fill_q   <= fill_d;
            rx_hi_q  <= rx_hi_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            bit8_q   <= bit8_d;
            pen_q    <= pen_d;
            ohel_q   <= ohel_d;
            data_q   <= data_d;
            bidx_q   <= bidx_d;
            par_q    <= par_d;
            pbit_q   <= pbit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only observable after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign head     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign rxrdy    = (count_q != '0);
    assign rx_out   = head[7:0];
    assign perr     = head[8];
    assign ferr     = head[9];
    assign ovf      = ovf_q;
    assign rx_level = count_q;
`ifdef RX_BREAK_DETECT_EN
    assign brk      = head[10];
`else
    assign brk      = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo_engine.sv
// Directed bench for rx_fifo_engine: serial frames are driven on rx and expected FIFO entries are queued and compared on pop.
module tb_rx_fifo_engine;

    localparam int AW = 3;
    localparam int BT = 109;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        bit8;
    logic        pen;
    logic        ohel;
    logic [19:0] br;
    logic        read;
    logic        rxrdy;
    logic [7:0]  rx_out;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic        ovf;
    logic [AW:0] rx_level;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [10:0] exp_q[$];       // {brk, ferr, perr, data}
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    rx_fifo_engine #(.AW(AW), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .bit8     (bit8),
        .pen      (pen),
        .ohel     (ohel),
        .br       (br),
        .read     (read),
        .rxrdy    (rxrdy),
        .rx_out   (rx_out),
        .perr     (perr),
        .ferr     (ferr),
        .brk      (brk),
        .ovf      (ovf),
        .rx_level (rx_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        read  = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(5);
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    function automatic logic [10:0] model_entry(input logic [7:0] d, input int nbits, input logic p_en,
                                                input logic odd, input logic p_bit, input logic stop_bit);
        logic [7:0] m;
        logic       p_exp;
        logic       pe;
        m     = (nbits == 8) ? d : {1'b0, d[6:0]};
        p_exp = (^m) ^ odd;
        pe    = p_en && (p_bit != p_exp);
        return {1'b0, ~stop_bit, pe, m};
    endfunction

    task automatic push_expect(input logic [10:0] e);
        if (exp_q.size() < (1 << AW)) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input int nbits, input logic p_en, input logic odd,
                         input logic p_bit, input logic stop_bit, input int bt);
        bit8 = (nbits == 8);
        pen  = p_en;
        ohel = odd;
        hold(1'b0, bt);
        for (int i = 0; i < nbits; i++) hold(d[i], bt);
        if (p_en) hold(p_bit, bt);
        hold(stop_bit, bt);
        rx = 1'b1;
        push_expect(model_entry(d, nbits, p_en, odd, p_bit, stop_bit));
    endtask

    task automatic pop_check(input string tag);
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " rxrdy"}, rxrdy, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " rxrdy"},  rxrdy,  1);
        check({tag, " rx_out"}, rx_out, e[7:0]);
        check({tag, " perr"},   perr,   e[8]);
        check({tag, " ferr"},   ferr,   e[9]);
        check({tag, " brk"},    brk,    e[10]);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        rx    = 1'b1;
        read  = 1'b0;
        bit8  = 1'b1;
        pen   = 1'b0;
        ohel  = 1'b0;
        br    = 20'(BT);
        do_reset();

        check("reset rxrdy",    rxrdy,    0);
        check("reset rx_out",   rx_out,   0);
        check("reset perr",     perr,     0);
        check("reset ferr",     ferr,     0);
        check("reset brk",      brk,      0);
        check("reset ovf",      ovf,      0);
        check("reset rx_level", rx_level, 0);

        frame(8'h55, 8, 1'b1, 1'b1, 1'b1, 1'b1, BT);
        idle(20);
        check("8O1 level", rx_level, exp_q.size());
        pop_check("8O1 good");

        frame(8'h55, 8, 1'b1, 1'b1, 1'b0, 1'b1, BT);
        idle(20);
        pop_check("8O1 bad parity");
        check("8O1 after read rxrdy", rxrdy,    0);
        check("8O1 after read level", rx_level, 0);

        frame(8'h41, 7, 1'b0, 1'b0, 1'b0, 1'b0, BT);
        idle(20);
        check("7N1 level", rx_level, exp_q.size());
        pop_check("7N1 stop low");
        do_reset();

        hold(1'b0, 30);
        hold(1'b1, 200);
        check("glitch level", rx_level, 0);
        check("glitch rxrdy", rxrdy,    0);

        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("empty read level",  rx_level, 0);
        check("empty read rx_out", rx_out,   0);

        br = 20'd1;
        frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle(20);
        check("br clamp level", rx_level, exp_q.size());
        pop_check("br clamp");
        br = 20'(BT);

        for (int i = 1; i <= 9; i++) begin
            frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, BT);
        end
        idle(20);
        check("full level", rx_level, exp_q.size());
        check("full ovf",   ovf,      exp_ovf);
        check("full head",  rx_out,   8'h01);
        for (int i = 0; i < 8; i++) begin
            pop_check("drain");
            if (i == 0) begin
                exp_ovf = 1'b0;
                check("ovf after pop", ovf, exp_ovf);
            end
        end
        check("drained level", rx_level, 0);

        // Reset while the line is low must abort the frame and must not treat the low line as a new start.
        bit8 = 1'b1;
        pen  = 1'b0;
        hold(1'b0, BT);
        hold(1'b1, BT);
        rx    = 1'b0;
        idle(BT / 2);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        exp_q.delete();
        hold(1'b0, 300);
        hold(1'b1, 300);
        check("midframe reset level", rx_level, 0);
        frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, BT);
        idle(20);
        pop_check("after midframe reset");
        do_reset();

        // 8N1 frames repeat every 1036 clocks while the line is low, so 30 bit times hold three complete zero frames.
        bit8 = 1'b1;
        pen  = 1'b0;
        hold(1'b0, 30 * BT);
        rx = 1'b1;
`ifdef RX_BREAK_DETECT_EN
        push_expect(11'h600);
        idle(1500);
`else
        for (int i = 0; i < 3; i++) push_expect(11'h200);
        idle(200);
`endif
        check("break level", rx_level, exp_q.size());
        while (exp_q.size() != 0) pop_check("break");
        check("break drained rxrdy", rxrdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
